// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between the CPU
// datapath and a debug/program-loader requester, one transaction at a time.
//
// Ports:
//   clk, reset         - rising-edge clock, synchronous active-high reset
//   cpu_req/we/addr/wdata -> cpu_rdata, cpu_ready  (CPU requester)
//   dbg_req/we/addr/wdata -> dbg_rdata, dbg_ready  (debug requester)
//   mem_addr, mem_wdata, mem_mem_ena, mem_wr_ena, mem_rdata (memory side)
//   busy               - high whenever the arbiter is not idle
//
// A grant latches the winner's operands, so requester inputs may move
// once granted without disturbing the access. Ties go to the requester
// that was not served last.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,

    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  dbg_ready,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_mem_ena,
    output logic                  mem_wr_ena,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  busy
);

    localparam int CW = $clog2(RD_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Requester encoding: 0 = CPU, 1 = debug.
    localparam logic SEL_CPU = 1'b0;
    localparam logic SEL_DBG = 1'b1;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          last_grant;
    logic          grant;
    logic          we_q;

    logic          grant_ok;
    logic          grant_sel;
    logic          capture;

    // Next-state and grant decision
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        grant_ok  = 1'b0;
        grant_sel = grant;
        capture   = 1'b0;

        unique case (state)
            IDLE: begin
                if (cpu_req && dbg_req) begin
                    grant_ok  = 1'b1;
                    grant_sel = ~last_grant;
                end else if (cpu_req) begin
                    grant_ok  = 1'b1;
                    grant_sel = SEL_CPU;
                end else if (dbg_req) begin
                    grant_ok  = 1'b1;
                    grant_sel = SEL_DBG;
                end
                if (grant_ok) begin
                    state_nx = ISSUE;
                end
            end

            ISSUE: begin
                // Reads always pass through WAIT: the data-valid cycle is
                // ISSUE+RD_LATENCY, which is a WAIT cycle for every legal
                // latency, so DONE lands one cycle later with rdata ready.
                if (we_q) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx   = CNT_LOAD;
                    state_nx = WAIT;
                end
            end

            WAIT: begin
                if (cnt == '0) begin
                    capture  = 1'b1;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end

            DONE: begin
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, grant bookkeeping, operand latch and read capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= SEL_DBG;
            grant      <= SEL_CPU;
            we_q       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;

            if (grant_ok) begin
                grant      <= grant_sel;
                last_grant <= grant_sel;
                if (grant_sel == SEL_DBG) begin
                    we_q      <= dbg_we;
                    mem_addr  <= dbg_addr;
                    mem_wdata <= dbg_wdata;
                end else begin
                    we_q      <= cpu_we;
                    mem_addr  <= cpu_addr;
                    mem_wdata <= cpu_wdata;
                end
            end

            if (capture) begin
                if (grant == SEL_DBG) begin
                    dbg_rdata <= mem_rdata;
                end else begin
                    cpu_rdata <= mem_rdata;
                end
            end
        end
    end

    // Outputs decode directly from registered state
    assign mem_mem_ena = (state == ISSUE);
    assign mem_wr_ena  = (state == ISSUE) && we_q;
    assign cpu_ready   = (state == DONE) && (grant == SEL_CPU);
    assign dbg_ready   = (state == DONE) && (grant == SEL_DBG);
    assign busy        = (state != IDLE);

endmodule
